// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type, latency limit, counter width and index-width helper for dmem_responder
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W = $clog2(LATENCY_MAX + 1);
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with synchronous per-lane write and combinational read by word index
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = idx_w(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];
    // byte-lane write; contents are never reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (i_we && i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
    end
    assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency single-outstanding memory responder; DMEM_BYTE_EN_EN enables per-lane stores
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int AW  = idx_w(DEPTH);
    localparam int LAT = (LATENCY < 1) ? 1 : (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be;
    logic             w_cur_we;
    logic [31:0]      w_cur_addr;
    logic [31:0]      w_rd;
    logic             w_err;
    logic             w_enter;
    logic             w_wr;
    logic [3:0]       w_be;
    // in IDLE the transaction is still on the inputs (needed when LATENCY=1 jumps straight to RESP)
    assign w_cur_we   = (r_state == IDLE) ? we : r_we;
    assign w_cur_addr = (r_state == IDLE) ? addr : r_addr;
    assign w_err      = (w_cur_addr[1:0] != 2'b00) || (w_cur_addr[31:2] >= 30'(DEPTH));
    assign w_enter    = (r_state == IDLE && req && LAT == 1) || (r_state == WAIT && r_cnt <= CNT_W'(1));
    assign w_wr       = (r_state == RESP) && r_we && !w_err;
    assign busy       = (r_state != IDLE);
`ifdef DMEM_BYTE_EN_EN
    assign w_be = r_be;
`else
    logic w_unused_be;
    assign w_unused_be = ^r_be;
    assign w_be = 4'hF;
`endif
    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk     (clk),
        .i_we    (w_wr),
        .i_be    (w_be),
        .i_idx   (w_cur_addr[AW+1:2]),
        .i_wdata (r_wdata),
        .o_rdata (w_rd)
    );
    // FSM, latency counter and registered response; response fields are set on the edge entering RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            done <= w_enter;
            err  <= w_enter && w_err;
            if (w_enter && (w_err || !w_cur_we)) rdata <= w_err ? 32'h0 : w_rd;
            case (r_state)
                IDLE: if (req) begin
                    r_we    <= we;
                    r_addr  <= addr;
                    r_wdata <= wdata;
                    r_be    <= be;
                    r_state <= (LAT == 1) ? RESP : WAIT;
                    r_cnt   <= CNT_W'(LAT - 1);
                end
                WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) r_state <= RESP;
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder at LATENCY=2 and LATENCY=1
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        req1 = 1'b0;
    logic        busy1, done1, err1;
    logic [31:0] rdata1;
    int          total = 0, bad = 0;
    logic [31:0] last_rd;
    logic        last_err;
    logic [31:0] exp10, exp14;
    int          ndone;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .LATENCY(2)) u2 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .busy(busy), .done(done), .rdata(rdata), .err(err)
    );
    dmem_responder #(.DEPTH(256), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .req(req1), .we(1'b0), .addr(32'h0), .wdata(32'h0), .be(4'h0),
        .busy(busy1), .done(done1), .rdata(rdata1), .err(err1)
    );

    task tick;
        @(posedge clk);
        #1;
    endtask

    task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b, input string tag);
        int n;
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        tick;
        req = 1'b0;
        n = 1;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        while (!done && n < 20) begin
            tick;
            n++;
        end
        chk({tag, ".lat"}, 32'(n), 32'd2);
        last_rd = rdata;
        last_err = err;
        tick;
        chk({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
`ifdef DMEM_BYTE_EN_EN
        exp10 = 32'hDEADBE55;
        exp14 = 32'h12345678;
`else
        exp10 = 32'h00000055;
        exp14 = 32'hCAFEF00D;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        chk("rst.busy1", 32'(busy1), 32'd0);
        rst = 1'b1;
        tick;
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st10");
        chk("st10.err", 32'(last_err), 32'd0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, "ld10");
        chk("ld10.rd", last_rd, 32'hDEADBEEF);
        chk("ld10.err", 32'(last_err), 32'd0);
        txn(1'b1, 32'h10, 32'h00000055, 4'b0001, "st10b");
        txn(1'b0, 32'h10, 32'h0, 4'hF, "ld10b");
        chk("ld10b.rd", last_rd, exp10);
        txn(1'b0, 32'h13, 32'h0, 4'hF, "ldmis");
        chk("ldmis.err", 32'(last_err), 32'd1);
        chk("ldmis.rd", last_rd, 32'h0);
        txn(1'b1, 32'h0, 32'h11111111, 4'hF, "st0");
        txn(1'b1, 32'h14, 32'h12345678, 4'hF, "st14");
        txn(1'b1, 32'h14, 32'hCAFEF00D, 4'h0, "st14z");
        chk("st14z.err", 32'(last_err), 32'd0);
        txn(1'b0, 32'h14, 32'h0, 4'hF, "ld14");
        chk("ld14.rd", last_rd, exp14);
        txn(1'b1, 32'h1C, 32'h00005A5A, 4'hF, "st1c");
        chk("st1c.hold", last_rd, exp14);
        txn(1'b0, 32'h400, 32'h0, 4'hF, "ldoor");
        chk("ldoor.err", 32'(last_err), 32'd1);
        chk("ldoor.rd", last_rd, 32'h0);
        txn(1'b1, 32'h400, 32'hAAAAAAAA, 4'hF, "stoor");
        chk("stoor.err", 32'(last_err), 32'd1);
        txn(1'b0, 32'h0, 32'h0, 4'hF, "ld0");
        chk("ld0.rd", last_rd, 32'h11111111);
        chk("ld0.err", 32'(last_err), 32'd0);
        // request changes during WAIT must be ignored
        req = 1'b1; we = 1'b1; addr = 32'h18; wdata = 32'h77; be = 4'hF;
        tick;
        addr = 32'h1C; wdata = 32'h99;
        ndone = 0;
        tick;
        if (done) ndone++;
        req = 1'b0;
        repeat (4) begin
            tick;
            if (done) ndone++;
        end
        chk("ign.ndone", 32'(ndone), 32'd1);
        txn(1'b0, 32'h1C, 32'h0, 4'hF, "ld1c");
        chk("ld1c.rd", last_rd, 32'h00005A5A);
        txn(1'b0, 32'h18, 32'h0, 4'hF, "ld18");
        chk("ld18.rd", last_rd, 32'h77);
        // reset one cycle before RESP abandons the store
        req = 1'b1; we = 1'b1; addr = 32'h14; wdata = 32'h0BADF00D; be = 4'hF;
        tick;
        req = 1'b0;
        rst = 1'b0;
        #1;
        chk("ab.busy", 32'(busy), 32'd0);
        chk("ab.done", 32'(done), 32'd0);
        chk("ab.rdata", rdata, 32'd0);
        @(posedge clk);
        #1;
        chk("ab.done2", 32'(done), 32'd0);
        rst = 1'b1;
        tick;
        chk("ab.done3", 32'(done), 32'd0);
        txn(1'b0, 32'h14, 32'h0, 4'hF, "ab.ld14");
        chk("ab.ld14.rd", last_rd, exp14);
        // LATENCY=1 with req held high: accept on even cycles, done on odd cycles
        req1 = 1'b1;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("l1.busy%0d", k), 32'(busy1), 32'(k % 2));
            chk($sformatf("l1.done%0d", k), 32'(done1), 32'(k % 2));
            if (done1) ndone++;
            tick;
        end
        req1 = 1'b0;
        chk("l1.ndone", 32'(ndone), 32'd5);
        chk("l1.err", 32'(err1), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, giving the number of 32-bit words of storage.
REQ-002 SHALL have parameter LATENCY, default 2, giving the cycles from request acceptance to response; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req, input, 1 bit: the requester has a valid transaction.
REQ-006 SHALL have port we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port addr, input, 32 bits: byte address.
REQ-008 SHALL have port wdata, input, 32 bits: store data.
REQ-009 SHALL have port be, input, 4 bits: byte-lane enables, where be[i] covers wdata[8i+7:8i].
REQ-010 SHALL have port busy, output, 1 bit: high while a transaction is in flight.
REQ-011 SHALL have port done, output, 1 bit: one-cycle response strobe.
REQ-012 SHALL have port rdata, output, 32 bits: load data.
REQ-013 SHALL have port err, output, 1 bit: the current response is an error; valid only with done.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT and RESP; busy is high exactly when the state is not IDLE.
REQ-015 SHALL accept a request only in IDLE with req=1, capturing we, addr, wdata and be on that edge.
REQ-016 SHALL ignore req while busy, with no queueing; the requester re-presents after done.
REQ-017 SHALL, on acceptance, go to WAIT and load the counter with LATENCY-1; with LATENCY=1 it goes directly to RESP.
REQ-018 SHALL, in WAIT, decrement the counter each cycle and enter RESP when the counter is 0.
REQ-019 SHALL, in RESP, assert done for exactly one cycle, then return to IDLE.
REQ-020 SHALL assert done in the cycle LATENCY cycles after the acceptance cycle; back-to-back throughput is one transaction per LATENCY+1 cycles.
REQ-021 SHALL commit a store to the array at the end of the RESP cycle.
REQ-022 SHALL present load data on rdata in the RESP cycle and hold it until the next load response.
REQ-023 SHALL flag an error when addr[1:0] != 0 or addr[31:2] >= DEPTH.
REQ-024 SHALL, on an error, assert err with done, suppress any write, and drive rdata to 0.
REQ-025 SHALL return a full word on loads regardless of be.
REQ-026 SHALL make a load to an address stored in an earlier completed transaction return the stored value (no stale read).

Reset
REQ-027 SHALL, while rst=0, immediately force the state to IDLE, busy=0, done=0, err=0, rdata=0 and the counter to 0.
REQ-028 SHALL abandon an in-flight transaction when rst asserts before its RESP edge: no write commits and no done is produced.
REQ-029 SHALL leave array contents unaffected by reset; the power-up contents are unspecified.

Configuration
REQ-030 SHALL honour macro DMEM_BYTE_EN_EN.
REQ-031 SHALL, with DMEM_BYTE_EN_EN defined, write only the lanes whose be bit is 1; be=4'b0000 writes nothing but still completes with done.
REQ-032 SHALL, without DMEM_BYTE_EN_EN, keep the be port, ignore it, and write all four lanes on every store.

Structure
REQ-033 SHALL take from shared package dmem_pkg the FSM state enum, the LATENCY_MAX=15 constant and the counter width.
REQ-034 SHALL place the storage in one sub-module, dmem_array: synchronous write with per-lane enables and combinational read by word index.
REQ-035 SHALL keep the FSM, counter, address check and response registers in dmem_responder.

Verification
REQ-036 SHALL cover: LATENCY=2, store addr=0x10, wdata=0xDEADBEEF, be=4'hF, then load addr=0x10 -> done two cycles after each acceptance, rdata=0xDEADBEEF, err=0.
REQ-037 SHALL cover: DMEM_BYTE_EN_EN defined, word 0x10=0xDEADBEEF, store wdata=0x00000055 with be=4'b0001, then load -> rdata=0xDEADBE55; with the macro undefined -> rdata=0x00000055.
REQ-038 SHALL cover: load addr=0x13 (misaligned), and with DEPTH=256 load addr=0x400 (out of range) -> done with err=1 and rdata=0; a store to 0x400 changes no word.
REQ-039 SHALL cover: req held high for 10 cycles with LATENCY=1 -> accepts on cycles 0, 2, 4, 6, 8; done on cycles 1, 3, 5, 7, 9.
REQ-040 SHALL cover: store accepted, then rst pulsed low one cycle before RESP -> no done, busy=0 immediately, and a following load returns the pre-store word.
REQ-041 SHALL cover: a new request presented during WAIT -> ignored; done count equals accepted count.
